// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: watches one slow toggle signal from the fast clk domain.
//
// The block produces single-cycle rise/fall ticks that downstream logic uses as
// clock enables. It measures the rise-to-rise period in clk cycles and checks it
// against EXP_PERIOD +/- TOL. It also flags loss of the slow signal when no rising
// edge arrives within TIMEOUT cycles.
//
// Build option:
//   SLOW_MON_SYNC_EN  defined   -> two-flop synchronizer ahead of the edge detector
//                                  (tick latency 3). Use this for pins or other domains.
//   SLOW_MON_SYNC_EN  undefined -> slow_in_i goes straight to the edge detector
//                                  (tick latency 1). Use this only for a clk-domain register.
// Measured periods are the same in both builds, because the extra delay is
// identical for every edge.
//
// Reset is synchronous and active low.

module slow_clk_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EXP_PERIOD = 50000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned TIMEOUT    = 100000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             slow_in_i,
  output logic             rise_tick_o,
  output logic             fall_tick_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             locked_o,
  output logic             lost_o,
  output logic             mismatch_o
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------

  // Tolerance window held one bit wider than the counter, so that EXP+TOL and a
  // saturated count + 1 cannot overflow. The low bound clamps at zero.
  localparam logic [CNT_W:0] TolLo = (EXP_PERIOD > TOL) ?
                                     (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0] TolHi = (CNT_W+1)'(EXP_PERIOD) + (CNT_W+1)'(TOL);

  // Counter value seen in the last cycle before loss is declared.
  localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StLocked,
    StLost
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------

  logic slow_s;

`ifdef SLOW_MON_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for an asynchronous slow_in_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= slow_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign slow_s = sync2_q;
`else
  assign slow_s = slow_in_i;
`endif

  logic hist_q;

  // History flop: holds the previous level of the (synchronized) input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= slow_s;
    end
  end

  logic rise, fall;
  assign rise = slow_s & ~hist_q;
  assign fall = ~slow_s & hist_q;

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on a detected rise, otherwise count up and saturate without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The period just ended includes the rise cycle itself, hence +1.
  logic [CNT_W:0] meas;
  logic           in_tol;
  logic           timeout;

  assign meas    = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign in_tol  = (meas >= TolLo) && (meas <= TolHi);
  assign timeout = (cnt_q == CntTimeout);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A rise outranks a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StAcq;
      end
      StAcq, StLocked: begin
        if (rise) begin
          state_d = in_tol ? StLocked : StAcq;
        end else if (timeout) begin
          state_d = StLost;
        end
      end
      StLost: begin
        if (rise) state_d = StAcq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Measurement outputs. A rise is only measured when a reference rise exists,
  // which is the case in ACQ and LOCKED.
  logic             measure;
  logic             period_vld_d;
  logic             mismatch_d;
  logic [CNT_W-1:0] period_q, period_d;

  always_comb begin
    measure      = rise && ((state_q == StAcq) || (state_q == StLocked));
    period_vld_d = measure;
    mismatch_d   = measure && !in_tol;
    period_d     = period_q;
    if (measure) begin
      // If the counter has saturated, report all-ones rather than a wrapped value.
      period_d = meas[CNT_W] ? CntMax : meas[CNT_W-1:0];
    end
  end

  logic rise_tick_q, fall_tick_q, period_vld_q, mismatch_q;

  // Registered pulses and period, all aligned with the rise tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rise_tick_q  <= 1'b0;
      fall_tick_q  <= 1'b0;
      period_vld_q <= 1'b0;
      mismatch_q   <= 1'b0;
      period_q     <= '0;
    end else begin
      rise_tick_q  <= rise;
      fall_tick_q  <= fall;
      period_vld_q <= period_vld_d;
      mismatch_q   <= mismatch_d;
      period_q     <= period_d;
    end
  end

  assign rise_tick_o  = rise_tick_q;
  assign fall_tick_o  = fall_tick_q;
  assign period_vld_o = period_vld_q;
  assign mismatch_o   = mismatch_q;
  assign period_o     = period_q;
  assign locked_o     = (state_q == StLocked);
  assign lost_o       = (state_q == StLost);

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Testbench for slow_clk_monitor. It uses small parameters and drives directed
// phases followed by random periods. A reference model tracks edges and
// timestamps and checks every output on every cycle.
module tb_slow_clk_monitor;

  localparam int CntW = 32;
  localparam int Exp  = 20;
  localparam int Tol  = 2;
  localparam int Tmo  = 40;
`ifdef SLOW_MON_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            slow_in_i = 1'b0;
  logic            rise_tick_o, fall_tick_o, period_vld_o, locked_o, lost_o, mismatch_o;
  logic [CntW-1:0] period_o;

  slow_clk_monitor #(
    .CNT_W      (CntW),
    .EXP_PERIOD (Exp),
    .TOL        (Tol),
    .TIMEOUT    (Tmo)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slow_in_i    (slow_in_i),
    .rise_tick_o  (rise_tick_o),
    .fall_tick_o  (fall_tick_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .locked_o     (locked_o),
    .lost_o       (lost_o),
    .mismatch_o   (mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: input samples per posedge, a rise timestamp, and a
  // tracking mode (0: no reference rise yet, 1: tracking, 2: signal lost).
  logic        m_line [0:3];
  int          m_cyc    = 0;
  int          m_last   = 0;
  int          m_mode   = 0;
  bit          m_locked = 0;
  logic [31:0] m_period = '0;
  bit          m_vld = 0, m_mis = 0, m_rt = 0, m_ft = 0;

  task automatic model_step(input logic v, input logic rn);
    int p;
    m_cyc++;
    m_vld = 0; m_mis = 0; m_rt = 0; m_ft = 0;
    if (!rn) begin
      m_mode = 0; m_locked = 0; m_period = '0;
      for (int i = 0; i < 4; i++) m_line[i] = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = v;
      // An edge on the input becomes visible Lat posedges after it is sampled.
      m_rt = m_line[Lat-1] && !m_line[Lat];
      m_ft = !m_line[Lat-1] && m_line[Lat];
      if (m_rt) begin
        if (m_mode == 1) begin
          p        = m_cyc - m_last;
          m_period = p;
          m_vld    = 1;
          if (p >= Exp - Tol && p <= Exp + Tol) m_locked = 1;
          else begin
            m_locked = 0;
            m_mis    = 1;
          end
        end else begin
          m_locked = 0;
        end
        m_mode = 1;
        m_last = m_cyc;
      end else if (m_mode == 1 && (m_cyc - m_last) == Tmo) begin
        m_mode   = 2;
        m_locked = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, m_cyc, obs, exp);
    end
  endtask

  // One clock: drive away from the edge, step the model, sample after the edge.
  task automatic cyc(input logic v, input logic rn);
    @(negedge clk_i);
    slow_in_i = v;
    rst_ni    = rn;
    @(posedge clk_i);
    model_step(v, rn);
    #1;
    check("rise_tick",  32'(rise_tick_o),  32'(m_rt));
    check("fall_tick",  32'(fall_tick_o),  32'(m_ft));
    check("period_vld", 32'(period_vld_o), 32'(m_vld));
    check("mismatch",   32'(mismatch_o),   32'(m_mis));
    check("period",     period_o,          m_period);
    check("locked",     32'(locked_o),     32'(m_locked));
    check("lost",       32'(lost_o),       32'(m_mode == 2));
  endtask

  task automatic run_level(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v, 1'b1);
  endtask

  task automatic run_period(input int hi, input int lo);
    run_level(1'b1, hi);
    run_level(1'b0, lo);
  endtask

  int first_tick;

  initial begin
    for (int i = 0; i < 4; i++) m_line[i] = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_locked", 32'(locked_o), 32'd0);
    run_level(1'b0, 3);

    // Nominal 20-cycle toggling
    for (int i = 0; i < 4; i++) run_period(10, 10);
    run_level(1'b1, 10);
    run_level(1'b0, Lat);
    check("nominal_period", period_o, 32'd20);
    check("nominal_locked", 32'(locked_o), 32'd1);
    run_level(1'b0, 10 - Lat);

    // One 23-cycle period, then recovery
    run_period(12, 11);
    for (int i = 0; i < 3; i++) run_period(10, 10);

    // Loss: hold the input, then resume
    run_level(1'b0, 60);
    check("hold_lost", 32'(lost_o), 32'd1);
    for (int i = 0; i < 4; i++) run_period(10, 10);

    // A rise that lands exactly on the timeout cycle
    run_period(20, 20);
    run_level(1'b1, Lat);
    check("edge_timeout_period", period_o, 32'd40);
    check("edge_timeout_lost", 32'(lost_o), 32'd0);
    run_level(1'b1, 10 - Lat);
    run_level(1'b0, 10);
    for (int i = 0; i < 3; i++) run_period(10, 10);

    // One-cycle reset in the middle of a period while locked
    run_level(1'b1, 5);
    cyc(1'b1, 1'b0);
    check("midreset_locked", 32'(locked_o), 32'd0);
    run_level(1'b1, 5);
    run_level(1'b0, 10);
    for (int i = 0; i < 3; i++) run_period(10, 10);

    // Input already high when reset is released
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    first_tick = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b1);
      if (rise_tick_o === 1'b1 && first_tick == 0) first_tick = i;
    end
    check("release_tick_cycle", 32'(first_tick), 32'(Lat));
    run_level(1'b1, 4);
    run_level(1'b0, 10);
    for (int i = 0; i < 3; i++) run_period(10, 10);

    // Random mix of periods, holds and resets
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        cyc(slow_in_i, 1'b0);
      end else if (r == 1) begin
        run_level(slow_in_i, int'($urandom_range(30, 55)));
      end else if (r == 2) begin
        run_period(int'($urandom_range(2, 25)), int'($urandom_range(2, 25)));
      end else begin
        run_period(int'($urandom_range(9, 11)), int'($urandom_range(9, 11)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
